siphash_stream_core: RTL and testbench



---
 rtl/siphash_stream_core_pkg.sv | 39 +++
 rtl/siphash_stream_core_round.sv | 29 ++
 rtl/siphash_stream_core.sv | 147 ++++++++++++++
 tb/tb_siphash_stream_core.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/siphash_stream_core_pkg.sv
// Shared SipHash constants, FSM encoding and the last-word padding helper.
package siphash_stream_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ABSORB   = 3'd1,
    ST_COMP     = 3'd2,
    ST_COMP_END = 3'd3,
    ST_FIN0     = 3'd4,
    ST_FIN1     = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  localparam logic [63:0] IV0    = 64'h736f6d6570736575;
  localparam logic [63:0] IV1    = 64'h646f72616e646f6d;
  localparam logic [63:0] IV2    = 64'h6c7967656e657261;
  localparam logic [63:0] IV3    = 64'h7465646279746573;
  localparam logic [63:0] PAD_FF = 64'h00000000000000ff;
  localparam logic [63:0] PAD_EE = 64'h00000000000000ee;
  localparam logic [63:0] PAD_DD = 64'h00000000000000dd;

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned r);
    return (x << r) | (x >> (32'd64 - r));
  endfunction

  // Final word: total length (mod 256) in the top byte, only the valid low bytes kept.
  function automatic logic [63:0] pad_last(input logic [63:0] data, input logic [2:0] nbytes,
                                           input logic [7:0] len);
    logic [63:0] w;
    w = 64'h0;
    w[63:56] = len + {5'b00000, nbytes};
    for (int i = 0; i < 7; i++) begin
      if (i < int'(nbytes)) w[8*i +: 8] = data[8*i +: 8];
      else                  w[8*i +: 8] = 8'h00;
    end
    return w;
  endfunction

endpackage

// File: rtl/siphash_stream_core_round.sv
// One combinational SipRound: v0..v3 in, next v0..v3 out.
module siphash_stream_core_round
  import siphash_stream_core_pkg::*;
(
  input  logic [63:0] v0,
  input  logic [63:0] v1,
  input  logic [63:0] v2,
  input  logic [63:0] v3,
  output logic [63:0] n0,
  output logic [63:0] n1,
  output logic [63:0] n2,
  output logic [63:0] n3
);

  logic [63:0] a0_s, a1_s, a2_s, a3_s, b0_s, b2_s;

  assign a0_s = v0 + v1;
  assign a1_s = rotl64(v1, 32'd13) ^ a0_s;
  assign a2_s = v2 + v3;
  assign a3_s = rotl64(v3, 32'd16) ^ a2_s;
  assign b0_s = rotl64(a0_s, 32'd32) + a3_s;
  assign b2_s = a2_s + a1_s;

  assign n0 = b0_s;
  assign n1 = rotl64(a1_s, 32'd17) ^ b2_s;
  assign n2 = rotl64(b2_s, 32'd32);
  assign n3 = rotl64(a3_s, 32'd21) ^ b0_s;

endmodule

// File: rtl/siphash_stream_core.sv
// Streaming SipHash-c-d core: absorbs 64-bit words with internal length padding,
// produces a 64-bit or 128-bit digest.
module siphash_stream_core
  import siphash_stream_core_pkg::*;
#(
  parameter int unsigned C_ROUNDS = 2,
  parameter int unsigned D_ROUNDS = 4,
  parameter int unsigned OUT128   = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [127:0]                key,
  input  logic                        start,
  input  logic                        block_valid,
  output logic                        block_ready,
  input  logic [63:0]                 block_data,
  input  logic                        block_last,
  input  logic [2:0]                  block_nbytes,
  output logic                        busy,
  output logic [64*(1+OUT128)-1:0]    digest,
  output logic                        digest_valid
);

  localparam int DW = 64 * (1 + int'(OUT128));
  localparam logic [63:0] V1_TWEAK = (OUT128 != 0) ? PAD_EE : 64'h0;
  localparam logic [63:0] V2_FINAL = (OUT128 != 0) ? PAD_EE : PAD_FF;

  state_e      state_r;
  logic [63:0] v0_r, v1_r, v2_r, v3_r, m_r;
  logic [7:0]  len_r;
  logic [3:0]  rnd_r;
  logic        last_r;
  logic [63:0] r0_s, r1_s, r2_s, r3_s, m_next_s, fold_s;

  siphash_stream_core_round u_round (
    .v0(v0_r), .v1(v1_r), .v2(v2_r), .v3(v3_r),
    .n0(r0_s), .n1(r1_s), .n2(r2_s), .n3(r3_s)
  );

  assign m_next_s = block_last ? pad_last(block_data, block_nbytes, len_r) : block_data;
  assign fold_s   = v0_r ^ v1_r ^ v2_r ^ v3_r;

  // Message FSM with round/byte counters and registered handshake/digest outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      v0_r         <= 64'h0;
      v1_r         <= 64'h0;
      v2_r         <= 64'h0;
      v3_r         <= 64'h0;
      m_r          <= 64'h0;
      len_r        <= 8'h0;
      rnd_r        <= 4'h0;
      last_r       <= 1'b0;
      block_ready  <= 1'b0;
      busy         <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            v0_r         <= key[63:0]   ^ IV0;
            v1_r         <= key[127:64] ^ IV1 ^ V1_TWEAK;
            v2_r         <= key[63:0]   ^ IV2;
            v3_r         <= key[127:64] ^ IV3;
            len_r        <= 8'h0;
            digest_valid <= 1'b0;
            busy         <= 1'b1;
            block_ready  <= 1'b1;
            state_r      <= ST_ABSORB;
          end else begin
            state_r <= state_r;
          end
        end
        ST_ABSORB: begin
          if (block_valid) begin
            m_r         <= m_next_s;
            v3_r        <= v3_r ^ m_next_s;
            last_r      <= block_last;
            len_r       <= block_last ? len_r : len_r + 8'd8;
            rnd_r       <= 4'h0;
            block_ready <= 1'b0;
            state_r     <= ST_COMP;
          end else begin
            state_r <= ST_ABSORB;
          end
        end
        ST_COMP: begin
          {v0_r, v1_r, v2_r, v3_r} <= {r0_s, r1_s, r2_s, r3_s};
          if (rnd_r == 4'(C_ROUNDS - 1)) begin
            rnd_r   <= 4'h0;
            state_r <= ST_COMP_END;
          end else begin
            rnd_r <= rnd_r + 4'd1;
          end
        end
        ST_COMP_END: begin
          v0_r  <= v0_r ^ m_r;
          rnd_r <= 4'h0;
          if (last_r) begin
            v2_r    <= v2_r ^ V2_FINAL;
            state_r <= ST_FIN0;
          end else begin
            block_ready <= 1'b1;
            state_r     <= ST_ABSORB;
          end
        end
        ST_FIN0: begin
          // The cycle after the last round folds the state into word0.
          if (rnd_r == 4'(D_ROUNDS)) begin
            digest <= DW'(fold_s);
            rnd_r  <= 4'h0;
            if (OUT128 != 0) begin
              v1_r    <= v1_r ^ PAD_DD;
              state_r <= ST_FIN1;
            end else begin
              digest_valid <= 1'b1;
              busy         <= 1'b0;
              state_r      <= ST_DONE;
            end
          end else begin
            {v0_r, v1_r, v2_r, v3_r} <= {r0_s, r1_s, r2_s, r3_s};
            rnd_r <= rnd_r + 4'd1;
          end
        end
        ST_FIN1: begin
          if (rnd_r == 4'(D_ROUNDS)) begin
            digest       <= digest | DW'({fold_s, 64'h0});
            digest_valid <= 1'b1;
            busy         <= 1'b0;
            state_r      <= ST_DONE;
          end else begin
            {v0_r, v1_r, v2_r, v3_r} <= {r0_s, r1_s, r2_s, r3_s};
            rnd_r <= rnd_r + 4'd1;
          end
        end
        default: begin
          block_ready <= 1'b0;
          busy        <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siphash_stream_core.sv
// Directed bench for siphash_stream_core: a 64-bit and a 128-bit instance share stimulus
// and are checked against a byte-level SipHash-2-4 reference.
module tb_siphash_stream_core;

  localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a09080706050403020100;

  logic         clk = 1'b0;
  logic         reset_n, start, block_valid, block_last;
  logic [63:0]  block_data;
  logic [2:0]   block_nbytes;
  logic [127:0] key;
  logic         rdy_a, busy_a, dv_a, rdy_b, busy_b, dv_b;
  logic [63:0]  dig_a;
  logic [127:0] dig_b;
  logic [127:0] exp_a, exp_b;
  logic [7:0]   msg_b [0:299];
  int           total = 0, bad = 0, cyc = 0;
  int           acc, gap, waits, la, lb;

  siphash_stream_core #(.C_ROUNDS(2), .D_ROUNDS(4), .OUT128(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .key(key), .start(start),
    .block_valid(block_valid), .block_ready(rdy_a), .block_data(block_data),
    .block_last(block_last), .block_nbytes(block_nbytes), .busy(busy_a),
    .digest(dig_a), .digest_valid(dv_a)
  );

  siphash_stream_core #(.C_ROUNDS(2), .D_ROUNDS(4), .OUT128(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .key(key), .start(start),
    .block_valid(block_valid), .block_ready(rdy_b), .block_data(block_data),
    .block_last(block_last), .block_nbytes(block_nbytes), .busy(busy_b),
    .digest(dig_b), .digest_valid(dv_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  function automatic logic [255:0] sr(input logic [255:0] s);
    logic [63:0] v0, v1, v2, v3;
    {v3, v2, v1, v0} = s;
    v0 = v0 + v1; v1 = rl(v1, 13); v1 = v1 ^ v0; v0 = rl(v0, 32);
    v2 = v2 + v3; v3 = rl(v3, 16); v3 = v3 ^ v2;
    v0 = v0 + v3; v3 = rl(v3, 21); v3 = v3 ^ v0;
    v2 = v2 + v1; v1 = rl(v1, 17); v1 = v1 ^ v2; v2 = rl(v2, 32);
    return {v3, v2, v1, v0};
  endfunction

  // SipHash-2-4 over msg_b[0..n-1]; returns {word1, word0} (word1 = 0 for 64-bit).
  function automatic logic [127:0] model(input int n, input bit o128);
    logic [63:0]  k0, k1, m, w0, w1;
    logic [255:0] s;
    k0 = KEY[63:0];
    k1 = KEY[127:64];
    s = {k1 ^ 64'h7465646279746573, k0 ^ 64'h6c7967656e657261,
         k1 ^ 64'h646f72616e646f6d ^ (o128 ? 64'hee : 64'h0), k0 ^ 64'h736f6d6570736575};
    for (int w = 0; w <= n / 8; w++) begin
      m = 64'h0;
      if (w < n / 8) begin
        for (int b = 0; b < 8; b++) m[8*b +: 8] = msg_b[8*w + b];
      end else begin
        for (int b = 0; b < n % 8; b++) m[8*b +: 8] = msg_b[8*w + b];
        m[63:56] = 8'(n);
      end
      s[255:192] = s[255:192] ^ m;
      for (int r = 0; r < 2; r++) s = sr(s);
      s[63:0] = s[63:0] ^ m;
    end
    s[191:128] = s[191:128] ^ (o128 ? 64'hee : 64'hff);
    for (int r = 0; r < 4; r++) s = sr(s);
    w0 = s[63:0] ^ s[127:64] ^ s[191:128] ^ s[255:192];
    w1 = 64'h0;
    if (o128) begin
      s[127:64] = s[127:64] ^ 64'hdd;
      for (int r = 0; r < 4; r++) s = sr(s);
      w1 = s[63:0] ^ s[127:64] ^ s[191:128] ^ s[255:192];
    end
    return {w1, w0};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whenever a digest is presented it must match the reference for the current message.
  always @(negedge clk) begin
    if (reset_n && dv_a) begin
      chk("digest64_stream", {64'h0, dig_a}, exp_a);
      chk("busy_low_when_valid", {127'h0, busy_a}, 128'h0);
    end
    if (reset_n && dv_b) chk("digest128_stream", dig_b, exp_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int n);
    exp_a = model(n, 1'b0);
    exp_b = model(n, 1'b1);
  endtask

  task automatic begin_msg(input int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_exp(n);
  endtask

  task automatic feed(input logic [63:0] d, input logic last, input logic [2:0] nb,
                      output int a, output int w);
    block_valid = 1'b1; block_data = d; block_last = last; block_nbytes = nb;
    a = -1; w = 0;
    for (int i = 0; i < 100; i++) begin
      if (rdy_a && rdy_b) begin
        tick();
        a = cyc;
        break;
      end
      w++;
      tick();
    end
    block_valid = 1'b0;
    if (a < 0) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no ready expected ready within 100 cycles");
    end
  endtask

  task automatic send_body(input int n, output int acc_last, output int gap_o, output int w_o);
    logic [63:0] d;
    int a, w, prev;
    prev = -1;
    for (int k = 0; k < n / 8; k++) begin
      for (int b = 0; b < 8; b++) d[8*b +: 8] = msg_b[8*k + b];
      feed(d, 1'b0, 3'd0, a, w);
      prev = a;
    end
    d = {$urandom, $urandom};
    for (int b = 0; b < n % 8; b++) d[8*b +: 8] = msg_b[8*(n/8) + b];
    feed(d, 1'b1, 3'(n % 8), a, w);
    acc_last = a;
    w_o = w;
    gap_o = (prev >= 0) ? a - prev : -1;
  endtask

  task automatic wait_done(input int a, output int lat_a, output int lat_b);
    int ea, eb;
    ea = -1; eb = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dv_a && ea < 0) ea = cyc;
      if (dv_b && eb < 0) eb = cyc;
      if (ea >= 0 && eb >= 0) break;
    end
    if (ea < 0 || eb < 0) begin
      total++; bad++;
      $display("FAIL digest_timeout: got valid64=%0b valid128=%0b expected both 1", dv_a, dv_b);
    end
    lat_a = ea - a;
    lat_b = eb - a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; block_valid = 1'b0; block_last = 1'b0;
    block_data = 64'h0; block_nbytes = 3'd0; key = KEY;
    exp_a = 128'h0; exp_b = 128'h0;
    for (int i = 0; i < 300; i++) msg_b[i] = 8'(i);

    chk("model_empty64", model(0, 1'b0), {64'h0, 64'h726fdb47dd0e0e31});
    chk("model_1byte", model(1, 1'b0), {64'h0, 64'h74f839c593dc67fd});
    chk("model_8byte", model(8, 1'b0), {64'h0, 64'h93f5f5799a932462});
    chk("model_empty128", model(0, 1'b1), {64'h930255c71472f66d, 64'he6a825ba047f81a3});

    tick(); tick();
    chk("reset_ctrl", {125'h0, rdy_a, busy_a, dv_a}, 128'h0);
    chk("reset_ctrl128", {125'h0, rdy_b, busy_b, dv_b}, 128'h0);
    chk("reset_digest", {dig_a, 64'h0} | dig_b, 128'h0);
    reset_n = 1'b1;
    tick();

    // Empty message.
    begin_msg(0);
    chk("busy_after_start", {127'h0, busy_a}, 128'h1);
    send_body(0, acc, gap, waits);
    wait_done(acc, la, lb);
    chk("latency64", 128'(la), 128'd8);
    chk("latency128", 128'(lb), 128'd13);
    chk("digest_empty64", {64'h0, dig_a}, {64'h0, 64'h726fdb47dd0e0e31});
    chk("digest_empty128", dig_b, {64'h930255c71472f66d, 64'he6a825ba047f81a3});

    // One byte; upper bytes of the last word carry noise.
    begin_msg(1);
    send_body(1, acc, gap, waits);
    wait_done(acc, la, lb);
    chk("digest_1byte", {64'h0, dig_a}, {64'h0, 64'h74f839c593dc67fd});

    // One full word then an empty last word.
    begin_msg(8);
    send_body(8, acc, gap, waits);
    chk("accept_spacing", 128'(gap), 128'd4);
    chk("ready_low_samples", 128'(waits), 128'd3);
    wait_done(acc, la, lb);
    chk("digest_8byte", {64'h0, dig_a}, {64'h0, 64'h93f5f5799a932462});

    // Longer messages, including length wrap past 255 bytes.
    foreach (msg_b[i]) msg_b[i] = 8'($urandom);
    for (int t = 0; t < 3; t++) begin
      int n;
      n = (t == 0) ? 15 : (t == 1) ? 7 : 259;
      begin_msg(n);
      send_body(n, acc, gap, waits);
      wait_done(acc, la, lb);
      chk("digest_long64", {64'h0, dig_a}, exp_a);
      chk("digest_long128", dig_b, exp_b);
    end
    for (int i = 0; i < 300; i++) msg_b[i] = 8'(i);

    // Reset in the middle of compression.
    begin_msg(0);
    send_body(0, acc, gap, waits);
    tick();
    reset_n = 1'b0;
    #1;
    chk("midreset_ctrl", {125'h0, rdy_a, busy_a, dv_a}, 128'h0);
    chk("midreset_digest", {dig_a, 64'h0} | dig_b, 128'h0);
    tick();
    reset_n = 1'b1;
    tick();
    begin_msg(0);
    send_body(0, acc, gap, waits);
    wait_done(acc, la, lb);
    chk("post_reset_digest", {64'h0, dig_a}, {64'h0, 64'h726fdb47dd0e0e31});

    // start together with block_valid in DONE: start wins, word not taken.
    start = 1'b1; block_valid = 1'b1; block_last = 1'b1; block_nbytes = 3'd0; block_data = 64'h0;
    tick();
    start = 1'b0; block_valid = 1'b0;
    set_exp(1);
    chk("start_wins_valid", {125'h0, dv_a, rdy_a, busy_a}, 128'h3);
    send_body(1, acc, gap, waits);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(acc, la, lb);
    chk("start_in_comp_latency", 128'(la), 128'd8);
    chk("start_in_comp_digest", {64'h0, dig_a}, {64'h0, 64'h74f839c593dc67fd});
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
